adc_vol_filter: RTL and testbench

Conditioning stage between the modular ADC response stream and the voltage consumers (LEDR bar, 7-seg readout, acceleration). It accepts 12-bit samples for one selected channel and averages 2^AVG_LOG2 of them. It converts the mean to millivolts (mean*5000/4095, truncated) with a sequential restoring divider, which replaces the combinational divide. It emits a held 13-bit mV value plus a one-cycle valid strobe.

---
 rtl/adc_vol_filter.sv | 190 +++++++++++++++++++
 tb/tb_adc_vol_filter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_vol_filter.sv
// adc_vol_filter: averages 2^AVG_LOG2 ADC samples of one selected channel and
// converts the mean to millivolts (mean*FULL_MV/FULL_CODE, truncated) with a
// sequential restoring divider.
//
// Ports:
//   Clk          system clock
//   Reset        synchronous, active-high reset
//   sel_ch       channel whose samples are accepted
//   resp_valid   ADC response strobe
//   resp_channel ADC response channel
//   resp_data    ADC response sample (12 bit)
//   vol          last converted mean in mV, held between updates
//   vol_ch       channel that vol belongs to
//   vol_valid    one-cycle pulse when vol/vol_ch update
//   busy         high while loading the numerator or dividing
//   overrun      sticky flag: a matching sample arrived while not accumulating
module adc_vol_filter #(
  parameter int AVG_LOG2  = 2,
  parameter int FULL_MV   = 5000,
  parameter int FULL_CODE = 4095
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  sel_ch,
  input  logic        resp_valid,
  input  logic [4:0]  resp_channel,
  input  logic [11:0] resp_data,
  output logic [12:0] vol,
  output logic [4:0]  vol_ch,
  output logic        vol_valid,
  output logic        busy,
  output logic        overrun
);
  localparam int SUM_W  = 12 + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int NUM_W  = 25;
  localparam int REM_W  = 13;
  localparam int ITER_W = 5;
  localparam logic [CNT_W-1:0]  N_SAMPLES = CNT_W'(1 << AVG_LOG2);
  localparam logic [ITER_W-1:0] N_ITER    = ITER_W'(NUM_W);

  typedef enum logic [1:0] {ACCUM, LOAD, DIV, DONE} state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d, sum_base, sum_next;
  logic [CNT_W-1:0]   count_q, count_d, cnt_base, cnt_next;
  logic [4:0]         sel_q, sel_d;
  logic [11:0]        mean_q, mean_d;
  logic [4:0]         cur_ch_q, cur_ch_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [NUM_W-1:0]   quo_q, quo_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [REM_W:0]     step;
  logic [12:0]        vol_q, vol_d;
  logic [4:0]         vol_ch_q, vol_ch_d;
  logic               vol_valid_q, vol_valid_d;
  logic               overrun_q, overrun_d;
  logic               match;

  // One restoring-division step: shift in the next numerator bit and subtract
  // the divisor when it fits. Returns {quotient_bit, new_remainder}.
  // The remainder is always below FULL_CODE, so its top bit is zero before the shift.
  function automatic logic [REM_W:0] div_step(input logic [REM_W-1:0] rem,
                                              input logic nb);
    logic [REM_W-1:0] shifted;
    shifted = {rem[REM_W-2:0], nb};
    if (shifted >= REM_W'(FULL_CODE)) begin
      return {1'b1, shifted - REM_W'(FULL_CODE)};
    end
    return {1'b0, shifted};
  endfunction

  assign match = resp_valid && (resp_channel == sel_ch);

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    count_d     = count_q;
    sel_d       = sel_ch;
    mean_d      = mean_q;
    cur_ch_d    = cur_ch_q;
    num_d       = num_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    iter_d      = iter_q;
    vol_d       = vol_q;
    vol_ch_d    = vol_ch_q;
    vol_valid_d = 1'b0;
    overrun_d   = overrun_q;
    sum_base    = sum_q;
    cnt_base    = count_q;
    sum_next    = '0;
    cnt_next    = '0;
    step        = '0;

    // A matching sample outside ACCUM is dropped and flagged.
    if (match && state_q != ACCUM) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ACCUM: begin
        // A channel switch discards the partial average; the same-cycle
        // sample then starts the new average.
        if (sel_ch != sel_q && count_q != '0) begin
          sum_base = '0;
          cnt_base = '0;
        end
        sum_d   = sum_base;
        count_d = cnt_base;
        if (match) begin
          sum_next = sum_base + SUM_W'(resp_data);
          cnt_next = cnt_base + 1'b1;
          sum_d    = sum_next;
          count_d  = cnt_next;
          if (cnt_next == N_SAMPLES) begin
            mean_d   = 12'(sum_next >> AVG_LOG2);
            cur_ch_d = sel_ch;
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        num_d   = NUM_W'(mean_q) * NUM_W'(FULL_MV);
        rem_d   = '0;
        quo_d   = '0;
        iter_d  = '0;
        state_d = DIV;
      end
      DIV: begin
        // Iterations run while iter < 25; the cycle that sees iter == 25 hands off to DONE.
        if (iter_q == N_ITER) begin
          state_d = DONE;
        end else begin
          step   = div_step(rem_q, num_q[NUM_W-1]);
          rem_d  = step[REM_W-1:0];
          quo_d  = {quo_q[NUM_W-2:0], step[REM_W]};
          num_d  = {num_q[NUM_W-2:0], 1'b0};
          iter_d = iter_q + 1'b1;
        end
      end
      DONE: begin
        vol_d       = quo_q[12:0];
        vol_ch_d    = cur_ch_q;
        vol_valid_d = 1'b1;
        sum_d       = '0;
        count_d     = '0;
        state_d     = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ACCUM;
      sum_q       <= '0;
      count_q     <= '0;
      sel_q       <= '0;
      vol_q       <= '0;
      vol_ch_q    <= '0;
      vol_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      iter_q      <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      sel_q       <= sel_d;
      vol_q       <= vol_d;
      vol_ch_q    <= vol_ch_d;
      vol_valid_q <= vol_valid_d;
      overrun_q   <= overrun_d;
      iter_q      <= iter_d;
    end
    mean_q   <= mean_d;
    cur_ch_q <= cur_ch_d;
    num_q    <= num_d;
    rem_q    <= rem_d;
    quo_q    <= quo_d;
  end

  assign vol       = vol_q;
  assign vol_ch    = vol_ch_q;
  assign vol_valid = vol_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == LOAD) || (state_q == DIV);

endmodule

// File: tb/tb_adc_vol_filter.sv
// tb_adc_vol_filter: directed scenarios plus randomized traffic for
// adc_vol_filter, checked every cycle against a sample-queue reference model.
module tb_adc_vol_filter;
  localparam int N_AVG   = 4;
  localparam int LATENCY = 28;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [4:0]  sel_ch = 5'd1;
  logic        resp_valid = 1'b0;
  logic [4:0]  resp_channel = 5'd0;
  logic [11:0] resp_data = 12'd0;
  logic [12:0] vol;
  logic [4:0]  vol_ch;
  logic        vol_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  adc_vol_filter #(.AVG_LOG2(2), .FULL_MV(5000), .FULL_CODE(4095)) dut (
    .Clk(Clk), .Reset(Reset), .sel_ch(sel_ch), .resp_valid(resp_valid),
    .resp_channel(resp_channel), .resp_data(resp_data), .vol(vol),
    .vol_ch(vol_ch), .vol_valid(vol_valid), .busy(busy), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: accepted samples kept in a queue; a conversion is the
  // plain integer formula, delivered LATENCY edges after the last accept.
  int  m_q[$];
  bit  m_on = 0;
  int  m_left = 0;
  int  m_vol = 0, m_ch = 0, m_pend_vol = 0, m_pend_ch = 0;
  bit  m_vv = 0, m_ovr = 0;
  int  m_prev_sel = 0;

  function automatic int mv_of(input int mean);
    return (mean * 5000) / 4095;
  endfunction

  always @(posedge Clk) begin
    bit mt;
    int s;
    m_vv = 0;
    mt = resp_valid && (resp_channel == sel_ch);
    if (Reset) begin
      m_on = 1; m_left = 0; m_vol = 0; m_ch = 0; m_ovr = 0;
      m_q.delete();
    end else if (m_on) begin
      if (m_left > 0) begin
        if (mt) m_ovr = 1;
        m_left--;
        if (m_left == 0) begin
          m_vol = m_pend_vol; m_ch = m_pend_ch; m_vv = 1;
        end
      end else begin
        if (int'(sel_ch) != m_prev_sel && m_q.size() > 0) m_q.delete();
        if (mt) begin
          m_q.push_back(int'(resp_data));
          if (m_q.size() == N_AVG) begin
            s = 0;
            foreach (m_q[i]) s += m_q[i];
            m_pend_vol = mv_of(s / N_AVG);
            m_pend_ch  = int'(sel_ch);
            m_left     = LATENCY;
            m_q.delete();
          end
        end
      end
    end
    m_prev_sel = int'(sel_ch);
    #1;
    if (m_on) begin
      chk("vol", int'(vol), m_vol);
      chk("vol_ch", int'(vol_ch), m_ch);
      chk("vol_valid", int'(vol_valid), int'(m_vv));
      chk("busy", int'(busy), int'(m_left >= 2));
      chk("overrun", int'(overrun), int'(m_ovr));
    end
  end

  task automatic send(input int ch, input int d);
    @(negedge Clk);
    resp_valid = 1'b1; resp_channel = 5'(ch); resp_data = 12'(d);
    @(negedge Clk);
    resp_valid = 1'b0;
  endtask

  task automatic send4(input int ch, input int d0, input int d1, input int d2, input int d3);
    send(ch, d0); send(ch, d1); send(ch, d2); send(ch, d3);
  endtask

  task automatic wait_result(input string nm, input int ev, input int ech, output int lat);
    int n;
    bit got;
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(posedge Clk); #2;
      n++;
      if (vol_valid) got = 1;
    end
    lat = n;
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s: vol_valid never seen, expected vol %0d", nm, ev);
    end else begin
      chk({nm, "_vol"}, int'(vol), ev);
      chk({nm, "_ch"}, int'(vol_ch), ech);
    end
  endtask

  initial begin
    int lat;
    int pulses;
    // Literal pins for the model's conversion formula.
    chk("model_4095", mv_of(4095), 5000);
    chk("model_1001", mv_of(1001), 1222);

    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    chk("rst_vol", int'(vol), 0);
    chk("rst_valid", int'(vol_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr", int'(overrun), 0);

    sel_ch = 5'd1;
    send4(1, 4095, 4095, 4095, 4095);
    wait_result("full", 5000, 1, lat);
    chk("latency", lat, 28);
    @(posedge Clk); #2;
    chk("valid_one_cycle", int'(vol_valid), 0);

    send4(1, 1000, 1001, 1002, 1003);
    wait_result("mean1001", 1222, 1, lat);
    send4(1, 2048, 2048, 2048, 2048);
    wait_result("half", 2500, 1, lat);
    send4(1, 0, 0, 0, 0);
    wait_result("zero", 0, 1, lat);
    send4(1, 1, 1, 1, 1);
    wait_result("one", 1, 1, lat);

    // Channel-2 traffic interleaved with channel-1 zeros
    send(1, 0); send(2, 4095); send(1, 0); send(2, 4095);
    send(1, 0); send(2, 4095); send(1, 0);
    wait_result("interleave", 0, 1, lat);

    // Overrun: matching sample during the divide is dropped
    send4(1, 4095, 4095, 4095, 4095);
    repeat (4) @(negedge Clk);
    send(1, 0);
    chk("overrun_set", int'(overrun), 1);
    wait_result("ovr_first", 5000, 1, lat);
    send4(1, 2048, 2048, 2048, 2048);
    wait_result("ovr_next", 2500, 1, lat);
    chk("overrun_sticky", int'(overrun), 1);

    // Channel switch discards the partial ch1 average
    send(1, 4095); send(1, 4095);
    @(negedge Clk); sel_ch = 5'd3;
    send4(3, 2048, 2048, 2048, 2048);
    wait_result("switch", 2500, 3, lat);

    // Reset during the divide abandons the conversion
    sel_ch = 5'd1;
    send4(1, 4095, 4095, 4095, 4095);
    repeat (10) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("mid_rst_vol", int'(vol), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ovr", int'(overrun), 0);
    pulses = 0;
    repeat (40) begin
      @(posedge Clk); #2;
      if (vol_valid) pulses++;
    end
    chk("mid_rst_no_pulse", pulses, 0);
    send4(1, 1000, 1001, 1002, 1003);
    wait_result("after_rst", 1222, 1, lat);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      @(negedge Clk);
      Reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 99) < 2) sel_ch = 5'($urandom_range(1, 3));
      resp_valid   = ($urandom_range(0, 1) == 1);
      resp_channel = 5'($urandom_range(1, 3));
      r = $urandom_range(0, 9);
      resp_data = (r == 0) ? 12'd0 : (r == 1) ? 12'd4095 : 12'($urandom_range(0, 4095));
    end
    @(negedge Clk);
    Reset = 1'b0; resp_valid = 1'b0;
    repeat (40) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
